// File: rtl/darwin_rx_stream_if.sv
// AXI4-Stream beat bundle (16-bit data) between the link receiver and the host/DMA side.
interface darwin_rx_stream_if;
    logic [15:0] tdata;
    logic        tvalid;
    logic        tready;
    logic [1:0]  tkeep;
    logic        tlast;

    modport master (output tdata, output tvalid, output tkeep, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tkeep, input tlast, output tready);
endinterface

// File: rtl/darwin_rx_stream.sv
// Darwin3 west-link receiver: 2-phase REQ/ACK capture into a FWFT FIFO, emitted as a
// fixed-length-packet AXI4-Stream. The chip is throttled by withholding the ACK toggle.
module darwin_rx_stream #(
    parameter int FIFO_DEPTH = 8,
    parameter int PKT_WORDS  = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          RX_REQ,
    input  logic [15:0]                   RX_DATA,
    output logic                          RX_ACK,
    darwin_rx_stream_if.master            m_axis,
    output logic                          RX_DONE,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int BW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;

    logic              req_meta_reg;
    logic              req_s_reg;
    logic              ack_reg;
    logic [15:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg;
    logic [AW-1:0]     rd_ptr_reg;
    logic [LW-1:0]     count_reg;
    logic [15:0]       head_reg;
    logic [BW-1:0]     beat_reg;
    logic              done_reg;

    logic              pending;
    logic              full;
    logic              push;
    logic              valid;
    logic              pop;
    logic              last_beat;
    logic [AW-1:0]     rd_ptr_inc;

    // RX_DATA is deliberately not synchronised: the sender holds it from REQ toggle to ACK.
    assign pending    = req_s_reg ^ ack_reg;
    assign full       = (count_reg == LW'(FIFO_DEPTH));
    assign push       = pending & ~full;
    assign valid      = (count_reg != '0);
    assign pop        = valid & m_axis.tready;
    assign last_beat  = (beat_reg == BW'(PKT_WORDS - 1));
    assign rd_ptr_inc = rd_ptr_reg + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_meta_reg <= 1'b0;
            req_s_reg    <= 1'b0;
        end else begin
            req_meta_reg <= RX_REQ;
            req_s_reg    <= req_meta_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= RX_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_reg    <= 1'b0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            beat_reg   <= '0;
            done_reg   <= 1'b0;
        end else begin
            if (push) begin
                ack_reg    <= ~ack_reg;
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
                beat_reg   <= last_beat ? '0 : beat_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            done_reg <= pop & last_beat;
        end
    end

    // Registered head: a word pushed into an empty (or just-emptied) FIFO bypasses the array.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_reg <= '0;
        end else if (push && ((count_reg == '0) || ((count_reg == LW'(1)) && pop))) begin
            head_reg <= RX_DATA;
        end else if (pop && (count_reg > LW'(1))) begin
            head_reg <= mem[rd_ptr_inc];
        end
    end

    assign RX_ACK        = ack_reg;
    assign RX_DONE       = done_reg;
    assign FIFO_LEVEL    = count_reg;
    assign m_axis.tdata  = head_reg;
    assign m_axis.tvalid = valid;
    assign m_axis.tkeep  = 2'b11;
    assign m_axis.tlast  = valid & last_beat;
endmodule

// File: tb/tb_darwin_rx_stream.sv
// Self-checking bench for darwin_rx_stream: randomised link traffic and TREADY patterns
// checked against a word-queue model with packet position counting.
module tb_darwin_rx_stream;
    localparam int DEPTH = 8;
    localparam int PKT   = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_req = 1'b0;
    logic [15:0] rx_data = '0;
    logic        rx_ack;
    logic        rx_done;
    logic [3:0]  fifo_level;

    darwin_rx_stream_if axis ();

    darwin_rx_stream #(.FIFO_DEPTH(DEPTH), .PKT_WORDS(PKT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RX_REQ     (rx_req),
        .RX_DATA    (rx_data),
        .RX_ACK     (rx_ack),
        .m_axis     (axis),
        .RX_DONE    (rx_done),
        .FIFO_LEVEL (fifo_level)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int model_pos = 0;
    int done_cnt = 0;
    int sent_cnt = 0;
    bit tx_timeout = 0;
    logic [15:0] tx_q [$];
    logic [15:0] got_data [$];
    bit          got_last [$];

    initial axis.tready = 1'b0;

    always @(negedge clk) begin
        if (rst_n && axis.tvalid && axis.tready) begin
            $display("beat %0d: data=%h last=%b", got_data.size(), axis.tdata, axis.tlast);
            got_data.push_back(axis.tdata);
            got_last.push_back(axis.tlast);
        end
        if (rst_n && rx_done) done_cnt++;
    end

    function automatic bit exp_last(input int pos);
        return (pos % PKT) == PKT - 1;
    endfunction

    task automatic apply_reset(input int edges);
        @(posedge clk); #1;
        rst_n = 1'b0; rx_req = 1'b0; axis.tready = 1'b0;
        repeat (edges) @(posedge clk);
        #1 rst_n = 1'b1;
        got_data.delete(); got_last.delete();
        model_pos = 0; done_cnt = 0;
    endtask

    task automatic send_words(input int n, input int min_gap, input int max_gap);
        for (int i = 0; i < n; i++) begin
            int waited;
            @(posedge clk); #1;
            rx_data = tx_q[i];
            rx_req  = ~rx_req;
            waited  = 0;
            while (rx_ack !== rx_req && waited < 400) begin
                @(negedge clk); waited++;
            end
            if (rx_ack !== rx_req) begin tx_timeout = 1; return; end
            sent_cnt++;
            repeat ($urandom_range(max_gap, min_gap)) @(posedge clk);
        end
    endtask

    task automatic wait_beats(input int n, output bit ok);
        int cyc = 0;
        while (got_data.size() < n && cyc < 4000) begin @(negedge clk); cyc++; end
        ok = (got_data.size() >= n);
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk); #1;
        n_cmp++; if (rx_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", rx_ack); end
        n_cmp++; if (axis.tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got=%b exp=0", axis.tvalid); end
        n_cmp++; if (axis.tdata !== 16'h0) begin n_fail++; $display("FAIL reset_tdata got=%h exp=0000", axis.tdata); end
        n_cmp++; if (axis.tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got=%b exp=0", axis.tlast); end
        n_cmp++; if (rx_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", rx_done); end
        n_cmp++; if (fifo_level !== 4'd0) begin n_fail++; $display("FAIL reset_level got=%0d exp=0", fifo_level); end
        n_cmp++; if (axis.tkeep !== 2'b11) begin n_fail++; $display("FAIL reset_tkeep got=%b exp=11", axis.tkeep); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_word;
        apply_reset(2);
        @(posedge clk); #1;
        rx_data = 16'h1111; rx_req = 1'b1;
        for (int e = 1; e <= 2; e++) begin
            @(posedge clk); #1;
            n_cmp++; if (rx_ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_early edge=%0d got=%b exp=0", e, rx_ack); end
        end
        @(posedge clk); #1;
        n_cmp++; if (rx_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack_edge3 got=%b exp=1", rx_ack); end
        n_cmp++; if (axis.tvalid !== 1'b1 || axis.tdata !== 16'h1111) begin
            n_fail++; $display("FAIL single_head got=%b/%h exp=1/1111", axis.tvalid, axis.tdata); end
        n_cmp++; if (fifo_level !== 4'd1) begin n_fail++; $display("FAIL single_level got=%0d exp=1", fifo_level); end
        axis.tready = 1'b1;
        @(posedge clk); #1;
        axis.tready = 1'b0;
        n_cmp++; if (fifo_level !== 4'd0 || axis.tvalid !== 1'b0) begin
            n_fail++; $display("FAIL single_pop level=%0d tvalid=%b exp=0/0", fifo_level, axis.tvalid); end
        n_cmp++; if (got_data.size() != 1 || got_data[0] !== 16'h1111) begin
            n_fail++; $display("FAIL single_beat count=%0d exp=1 word 1111", got_data.size()); end
        model_pos = 1;
    endtask

    task automatic test_streaming;
        bit ok;
        int exp_done = 0;
        apply_reset(2);
        tx_q.delete();
        for (int k = 1; k <= 40; k++) tx_q.push_back(16'(k * 16'h1111));
        axis.tready = 1'b1; tx_timeout = 0;
        send_words(40, 3, 3);
        wait_beats(40, ok);
        repeat (3) @(negedge clk);
        n_cmp++; if (!ok || tx_timeout) begin n_fail++; $display("FAIL stream_timeout beats=%0d exp=40", got_data.size()); end
        for (int i = 0; i < 40 && i < got_data.size(); i++) begin
            if (exp_last(model_pos + i)) exp_done++;
            n_cmp++; if (got_data[i] !== tx_q[i] || got_last[i] !== exp_last(model_pos + i)) begin
                n_fail++; $display("FAIL stream_beat%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i], tx_q[i], exp_last(model_pos + i)); end
        end
        n_cmp++; if (done_cnt != exp_done) begin n_fail++; $display("FAIL stream_done got=%0d exp=%0d", done_cnt, exp_done); end
        n_cmp++; if (got_data.size() != 40) begin n_fail++; $display("FAIL stream_count got=%0d exp=40", got_data.size()); end
        model_pos += 40;
        axis.tready = 1'b0;
    endtask

    task automatic test_backpressure;
        bit ok;
        got_data.delete(); got_last.delete();
        tx_q.delete();
        for (int k = 0; k < 10; k++) tx_q.push_back(16'($urandom));
        axis.tready = 1'b0; sent_cnt = 0; tx_timeout = 0;
        fork
            send_words(10, 0, 2);
            begin
                int cyc = 0;
                while (fifo_level != 4'd8 && cyc < 1000) begin @(negedge clk); cyc++; end
                repeat (20) @(posedge clk); #1;
                n_cmp++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL bp_level got=%0d exp=8", fifo_level); end
                n_cmp++; if (sent_cnt != 8) begin n_fail++; $display("FAIL bp_acks got=%0d exp=8", sent_cnt); end
                n_cmp++; if (axis.tdata !== tx_q[0] || axis.tlast !== exp_last(model_pos)) begin
                    n_fail++; $display("FAIL bp_head got=%h/%b exp=%h/%b", axis.tdata, axis.tlast, tx_q[0], exp_last(model_pos)); end
                axis.tready = 1'b1;
            end
        join
        wait_beats(10, ok);
        n_cmp++; if (!ok || tx_timeout) begin n_fail++; $display("FAIL bp_timeout beats=%0d exp=10", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            n_cmp++; if (i >= 10 || got_data[i] !== tx_q[i] || got_last[i] !== exp_last(model_pos + i)) begin
                n_fail++; $display("FAIL bp_beat%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i], tx_q[i % 10], exp_last(model_pos + i)); end
        end
        model_pos += 10;
        axis.tready = 1'b0;
    endtask

    task automatic test_full_pop;
        bit ok;
        got_data.delete(); got_last.delete();
        tx_q.delete();
        for (int k = 0; k < 9; k++) tx_q.push_back(16'($urandom));
        axis.tready = 1'b0; sent_cnt = 0; tx_timeout = 0;
        fork
            send_words(9, 0, 0);
            begin
                int cyc = 0;
                while (sent_cnt < 8 && cyc < 1000) begin @(negedge clk); cyc++; end
                repeat (6) @(posedge clk); #1;
                n_cmp++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL fp_full got=%0d exp=8", fifo_level); end
                axis.tready = 1'b1;
                @(posedge clk); #1;
                axis.tready = 1'b0;
                n_cmp++; if (fifo_level !== 4'd7) begin n_fail++; $display("FAIL fp_pop got=%0d exp=7", fifo_level); end
                @(posedge clk); #1;
                n_cmp++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL fp_refill got=%0d exp=8", fifo_level); end
                axis.tready = 1'b1;
            end
        join
        wait_beats(9, ok);
        n_cmp++; if (!ok || tx_timeout) begin n_fail++; $display("FAIL fp_timeout beats=%0d exp=9", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            n_cmp++; if (i >= 9 || got_data[i] !== tx_q[i] || got_last[i] !== exp_last(model_pos + i)) begin
                n_fail++; $display("FAIL fp_beat%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i], tx_q[i % 9], exp_last(model_pos + i)); end
        end
        model_pos += 9;
        axis.tready = 1'b0;
    endtask

    task automatic test_stall;
        bit ok;
        got_data.delete(); got_last.delete();
        tx_q.delete();
        for (int k = 0; k < 30; k++) tx_q.push_back(16'($urandom));
        axis.tready = 1'b0; sent_cnt = 0; tx_timeout = 0;
        fork
            send_words(30, 0, 3);
            begin
                int cyc = 0;
                bit hold = 0;
                logic [15:0] hd = '0;
                logic hl = 1'b0;
                while (got_data.size() < 30 && cyc < 5000) begin
                    int idx;
                    @(posedge clk); #1; cyc++;
                    idx = got_data.size();
                    if (hold) begin
                        n_cmp++; if (axis.tvalid !== 1'b1 || axis.tdata !== hd || axis.tlast !== hl) begin
                            n_fail++; $display("FAIL stall_hold got=%b/%h/%b exp=1/%h/%b", axis.tvalid, axis.tdata, axis.tlast, hd, hl); end
                    end
                    if (axis.tvalid === 1'b1 && idx < 30) begin
                        n_cmp++; if (axis.tdata !== tx_q[idx] || axis.tlast !== exp_last(model_pos + idx)) begin
                            n_fail++; $display("FAIL stall_head%0d got=%h/%b exp=%h/%b", idx, axis.tdata, axis.tlast, tx_q[idx], exp_last(model_pos + idx)); end
                    end
                    n_cmp++; if (axis.tkeep !== 2'b11) begin n_fail++; $display("FAIL stall_tkeep got=%b exp=11", axis.tkeep); end
                    axis.tready = 1'($urandom_range(1, 0));
                    hold = axis.tvalid && !axis.tready;
                    hd = axis.tdata; hl = axis.tlast;
                end
            end
        join
        wait_beats(30, ok);
        n_cmp++; if (!ok || tx_timeout) begin n_fail++; $display("FAIL stall_timeout beats=%0d exp=30", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            n_cmp++; if (i >= 30 || got_data[i] !== tx_q[i] || got_last[i] !== exp_last(model_pos + i)) begin
                n_fail++; $display("FAIL stall_beat%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i], tx_q[i % 30], exp_last(model_pos + i)); end
        end
        model_pos += 30;
        axis.tready = 1'b0;
    endtask

    task automatic test_reset_mid;
        bit ok;
        int exp_done = 0;
        apply_reset(2);
        tx_q.delete();
        for (int k = 0; k < 3; k++) tx_q.push_back(16'($urandom));
        axis.tready = 1'b1; tx_timeout = 0;
        send_words(3, 0, 1);
        wait_beats(3, ok);
        axis.tready = 1'b0;
        tx_q.delete();
        for (int k = 0; k < 5; k++) tx_q.push_back(16'($urandom));
        send_words(5, 0, 1);
        repeat (4) @(posedge clk); #1;
        n_cmp++; if (fifo_level !== 4'd5) begin n_fail++; $display("FAIL rm_buffered got=%0d exp=5", fifo_level); end
        apply_reset(1);
        n_cmp++; if (axis.tvalid !== 1'b0 || fifo_level !== 4'd0 || rx_ack !== 1'b0) begin
            n_fail++; $display("FAIL rm_cleared tvalid=%b level=%0d ack=%b exp=0/0/0", axis.tvalid, fifo_level, rx_ack); end
        tx_q.delete();
        for (int k = 0; k < 16; k++) tx_q.push_back(16'($urandom));
        axis.tready = 1'b1;
        send_words(16, 0, 2);
        wait_beats(16, ok);
        repeat (3) @(negedge clk);
        n_cmp++; if (!ok || tx_timeout) begin n_fail++; $display("FAIL rm_timeout beats=%0d exp=16", got_data.size()); end
        for (int i = 0; i < got_data.size(); i++) begin
            if (exp_last(i)) exp_done++;
            n_cmp++; if (i >= 16 || got_data[i] !== tx_q[i] || got_last[i] !== exp_last(i)) begin
                n_fail++; $display("FAIL rm_beat%0d got=%h/%b exp=%h/%b", i, got_data[i], got_last[i], tx_q[i % 16], exp_last(i)); end
        end
        n_cmp++; if (done_cnt != exp_done) begin n_fail++; $display("FAIL rm_done got=%0d exp=%0d", done_cnt, exp_done); end
        axis.tready = 1'b0;
    endtask

    initial begin
        test_reset;
        test_single_word;
        test_streaming;
        test_backpressure;
        test_full_pop;
        test_stall;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
